// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the sequential pattern-detector family:
// the two-state shifter FSM encoding and the default word width.
package bit_serializer_pkg;

    // Default serializer word length in bits
    localparam int DEFAULT_WIDTH = 32;

    // Shifter FSM encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter, MSB first, with a one-word holding register
// so that back-to-back words leave the shift register with no gap cycles.
// Every output is decoded from registered state only.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             word_done
);

    localparam int            CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             last_bit;

    // Handshake: ready depends only on the holding-register flag, so a word
    // is accepted whenever the holding register is free.
    assign accept   = load_valid && !hold_full_q;
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

    // State and datapath registers; reset aborts any word in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic: leave SHIFT only when the last bit goes out with
    // nothing queued behind it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit && !hold_full_q && !accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: shift, reload from hold or input, or park a word in hold
    always_comb begin
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_d  = load_data;
                    cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (accept) begin
                        hold_d      = load_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held word follows the LSB with no gap
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    // Word arriving on the last-bit cycle goes straight in
                    sh_d  = load_data;
                    cnt_d = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                sh_d        = '0;
                hold_full_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // Outputs decoded from registers only
    always_comb begin
        load_ready = !hold_full_q;
        busy       = (state_q == ST_SHIFT);
        ser_out    = (state_q == ST_SHIFT) ? sh_q[WIDTH-1] : IDLE_LEVEL;
        word_done  = last_bit;
    end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed scenarios plus a random
// phase, all compared cycle by cycle against a queue-of-words reference.
module tb_bit_serializer;
    import bit_serializer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         ser_out;
    logic         busy;
    logic         word_done;

    bit_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .busy       (busy),
        .word_done  (word_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: queue of accepted words (head is shifting, second is
    // waiting) and the index of the bit of the head word currently on the line.
    logic [W-1:0] mq[$];
    int           idx = 0;

    bit rec = 1'b0;
    bit obs_bits[$];

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // One clock: compare outputs to the model, drive inputs, advance the model.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r, output bit acc);
        logic m_busy, m_ser, m_done, m_ready;
        logic [W-1:0] head;
        m_busy  = (mq.size() > 0);
        head    = m_busy ? mq[0] : '0;
        m_ser   = m_busy ? head[W-1-idx] : 1'b0;
        m_done  = m_busy && (idx == W-1);
        m_ready = (mq.size() < 2);
        check("ser_out",    ser_out,    m_ser);
        check("busy",       busy,       m_busy);
        check("word_done",  word_done,  m_done);
        check("load_ready", load_ready, m_ready);
        if (rec) obs_bits.push_back(ser_out);
        load_valid = v;
        load_data  = d;
        rstn       = r;
        @(posedge clk);
        acc = 1'b0;
        if (!r) begin
            mq.delete();
            idx = 0;
        end else begin
            acc = v && m_ready;
            if (m_busy) begin
                if (idx == W-1) begin
                    void'(mq.pop_front());
                    idx = 0;
                end else begin
                    idx++;
                end
            end
            if (acc) mq.push_back(d);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, a);
    endtask

    function automatic int count_110(input bit b[$]);
        int c = 0;
        for (int i = 0; i + 2 < b.size(); i++)
            if (b[i] && b[i+1] && !b[i+2]) c++;
        return c;
    endfunction

    initial begin
        bit a;
        bit exp_bits[$];
        logic [W-1:0] w3[3];
        logic [W-1:0] wd;
        int k;

        @(negedge clk);
        step(1'b0, '0, 1'b0, a);
        step(1'b1, 32'hFFFFFFFF, 1'b0, a);   // reset beats a simultaneous load

        // Single word, then idle; record the stream for the 110 count
        step(1'b1, 32'hD96CD9B4, 1'b1, a);
        rec = 1'b1;
        idle(36);
        rec = 1'b0;
        wd = 32'hD96CD9B4;
        for (int i = W-1; i >= 0; i--) exp_bits.push_back(wd[i]);
        for (int i = 0; i < 4; i++) exp_bits.push_back(1'b0);
        tests++;
        assert (count_110(obs_bits) === count_110(exp_bits)) else begin
            fails++;
            $error("FAIL count_110 observed=%0d expected=%0d",
                   count_110(obs_bits), count_110(exp_bits));
        end

        // Back-to-back words, second parked in hold
        step(1'b1, 32'hD96CD9B4, 1'b1, a);
        step(1'b1, 32'hFFFF0000, 1'b1, a);
        idle(70);

        // Three words offered continuously; advance only on acceptance
        w3[0] = $urandom; w3[1] = $urandom; w3[2] = $urandom;
        k = 0;
        for (int i = 0; i < 200 && k < 3; i++) begin
            step(1'b1, w3[k], 1'b1, a);
            if (a) k++;
        end
        tests++;
        assert (k === 3) else begin
            fails++;
            $error("FAIL three_words_accepted observed=%0d expected=%0d", k, 3);
        end
        idle(100);

        // Reset during bit 10 with a word held
        step(1'b1, $urandom, 1'b1, a);
        step(1'b1, $urandom, 1'b1, a);
        for (int i = 0; i < 40 && idx < 10; i++) step(1'b0, '0, 1'b1, a);
        step(1'b0, '0, 1'b0, a);
        idle(40);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 3) != 0, $urandom, ($urandom % 200) != 0, a);
        end
        idle(80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bit_serializer
